// File: rtl/counter_pkg.sv
// Shared types and constants for the three-digit BCD counter and its
// seven-segment decoders.
package counter_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned PUSH_W     = 2;

    typedef logic [DIGIT_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0]   seg_t;

    localparam bcd_t DIGIT_MAX = 4'd9;

    // Segment images {g,f,e,d,c,b,a}, active-high.
    localparam seg_t SEG_0   = 7'b0111111;
    localparam seg_t SEG_1   = 7'b0000110;
    localparam seg_t SEG_2   = 7'b1011011;
    localparam seg_t SEG_3   = 7'b1001111;
    localparam seg_t SEG_4   = 7'b1100110;
    localparam seg_t SEG_5   = 7'b1101101;
    localparam seg_t SEG_6   = 7'b1111101;
    localparam seg_t SEG_7   = 7'b0000111;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1101111;
    localparam seg_t SEG_OFF = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to seven-segment decoder. Non-BCD inputs blank the digit.
// Ports:
//   bcd_i  BCD digit 0-9 (10-15 -> all segments off)
//   seg_o  segment image {g,f,e,d,c,b,a}, inverted when SEG_ACTIVE_LOW=1
module bcd_to_7seg
    import counter_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic [DIGIT_W-1:0] bcd_i,
    output logic [SEG_W-1:0]   seg_o
);

    seg_t seg_c;

    // Active-high pattern lookup.
    always_comb begin
        seg_c = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_OFF;
        endcase
    end

    assign seg_o = SEG_ACTIVE_LOW ? ~seg_c : seg_c;

endmodule

// File: rtl/master_counter.sv
// Three-digit BCD up/down counter driven by two active-low buttons.
// Ports:
//   Clk        system clock
//   Rst        asynchronous active-low reset
//   Push       buttons, active-low: [1] = UP, [0] = DOWN, 2'b11 = idle
//   Cnt_o_LED  BCD count {hundreds, tens, ones}
//   Cnt_o_FND  seven-segment images {hundreds, tens, ones}, combinational
//   Carry      one-cycle pulse on 999->000 or 000->999
module master_counter
    import counter_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Push,
    output logic [11:0] Cnt_o_LED,
    output logic [20:0] Cnt_o_FND,
    output logic        Carry
);

    localparam int unsigned UP_BIT = 1;
    localparam int unsigned DN_BIT = 0;
    localparam int unsigned ARM_W  = 3;

    logic [PUSH_W-1:0]     sync1_q;
    logic [PUSH_W-1:0]     sync2_q;
    logic [PUSH_W-1:0]     prev_q;
    logic [ARM_W-1:0]      arm_q;
    bcd_t [NUM_DIGITS-1:0] digit_q;
    bcd_t [NUM_DIGITS-1:0] digit_d;
    logic                  carry_q;
    logic                  carry_d;
    logic                  up_evt;
    logic                  dn_evt;
    logic                  ripple;

    // Synchronizer, previous-value register and count state.
    // arm_q fills with ones after reset; its top bit marks the first cycle in
    // which prev_q holds a real button sample rather than its reset value, so
    // a button held through reset release is not mistaken for a new press.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            arm_q   <= '0;
            digit_q <= '0;
            carry_q <= 1'b0;
        end else begin
            sync1_q <= Push;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            arm_q   <= {arm_q[ARM_W-2:0], 1'b1};
            digit_q <= digit_d;
            carry_q <= carry_d;
        end
    end

    // Press detection and cascaded BCD increment/decrement.
    always_comb begin
        up_evt  = 1'b0;
        dn_evt  = 1'b0;
        digit_d = digit_q;
        carry_d = 1'b0;
        ripple  = 1'b1;

        if (arm_q[ARM_W-1]) begin
            up_evt = prev_q[UP_BIT] & ~sync2_q[UP_BIT];
            dn_evt = prev_q[DN_BIT] & ~sync2_q[DN_BIT];
        end

        if (up_evt && !dn_evt) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (ripple) begin
                    if (digit_q[i] == DIGIT_MAX) begin
                        digit_d[i] = '0;
                    end else begin
                        digit_d[i] = digit_q[i] + 4'd1;
                        ripple     = 1'b0;
                    end
                end
            end
            carry_d = ripple;
        end else if (dn_evt && !up_evt) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (ripple) begin
                    if (digit_q[i] == '0) begin
                        digit_d[i] = DIGIT_MAX;
                    end else begin
                        digit_d[i] = digit_q[i] - 4'd1;
                        ripple     = 1'b0;
                    end
                end
            end
            carry_d = ripple;
        end
    end

    assign Cnt_o_LED = digit_q;
    assign Carry     = carry_q;

    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_hun (
        .bcd_i (digit_q[2]),
        .seg_o (Cnt_o_FND[20:14])
    );

    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ten (
        .bcd_i (digit_q[1]),
        .seg_o (Cnt_o_FND[13:7])
    );

    bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_one (
        .bcd_i (digit_q[0]),
        .seg_o (Cnt_o_FND[6:0])
    );

endmodule

// File: tb/tb_master_counter.sv
// Testbench for master_counter: directed and random button presses checked
// against a decimal reference count (0..999) with wrap bookkeeping.
module tb_master_counter;

    logic        Clk  = 1'b0;
    logic        Rst  = 1'b0;
    logic [1:0]  Push = 2'b11;
    logic [11:0] Cnt_o_LED;
    logic [20:0] Cnt_o_FND;
    logic        Carry;

    int n_cmp = 0;
    int n_err = 0;
    int model = 0;
    int carry_total = 0;

    master_counter #(.SEG_ACTIVE_LOW(1'b0)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Push      (Push),
        .Cnt_o_LED (Cnt_o_LED),
        .Cnt_o_FND (Cnt_o_FND),
        .Carry     (Carry)
    );

    always #5 Clk = ~Clk;

    // Every cycle with Carry high adds one; a correct pulse adds exactly one.
    always @(negedge Clk) begin
        if (Carry === 1'b1) carry_total++;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [20:0] fnd_of(input int n);
        return {seg_of(n / 100), seg_of((n / 10) % 10), seg_of(n % 10)};
    endfunction

    function automatic logic [11:0] led_of(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_led"}, 32'(Cnt_o_LED), 32'(led_of(model)));
        check({tag, "_fnd"}, 32'(Cnt_o_FND), 32'(fnd_of(model)));
    endtask

    // Drive one button pattern for lo cycles, idle for hi cycles, then check.
    // Entered and left one time unit after a rising edge.
    task automatic press(input string tag, input logic [1:0] p, input int lo, input int hi);
        int c0;
        int wraps;
        c0    = carry_total;
        wraps = 0;
        Push  = p;
        repeat (lo) @(posedge Clk);
        #1;
        Push = 2'b11;
        repeat (hi) @(posedge Clk);
        #1;
        if (p == 2'b01) begin
            model = (model + 1) % 1000;
            if (model == 0) wraps = 1;
        end else if (p == 2'b10) begin
            if (model == 0) begin
                model = 999;
                wraps = 1;
            end else begin
                model = model - 1;
            end
        end
        check_state(tag);
        check({tag, "_carry"}, 32'(carry_total - c0), 32'(wraps));
    endtask

    // Asynchronous reset: checked before any clock edge, then released
    // between edges with Push left as the caller set it.
    task automatic do_reset(input string tag);
        Rst = 1'b0;
        #1;
        model = 0;
        check_state({tag, "_async"});
        check({tag, "_carry"}, 32'(Carry), 32'd0);
        repeat (3) @(posedge Clk);
        #2;
        Rst = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
    endtask

    initial begin
        int r;
        logic [1:0] p;

        // Reset with buttons idle.
        Push = 2'b11;
        @(posedge Clk);
        #1;
        do_reset("reset");
        check_state("reset_idle");
        check("reset_fnd_zero", 32'(Cnt_o_FND), 32'({3{7'b0111111}}));
        check("reset_carry_idle", 32'(Carry), 32'd0);

        // Press latency: edge k samples, count changes at edge k+2.
        Push = 2'b01;
        @(posedge Clk);
        #1;
        check("lat_k", 32'(Cnt_o_LED), 32'h000);
        @(posedge Clk);
        #1;
        check("lat_k1", 32'(Cnt_o_LED), 32'h000);
        @(posedge Clk);
        #1;
        check("lat_k2", 32'(Cnt_o_LED), 32'h001);
        repeat (7) @(posedge Clk);
        #1;
        Push = 2'b11;
        repeat (10) @(posedge Clk);
        #1;
        model = 1;
        check_state("lat_after");

        // Up count to 100.
        for (int i = 0; i < 99; i++) press("up", 2'b01, 10, 10);
        check("up100_led", 32'(Cnt_o_LED), 32'h100);
        check("up100_hund_seg", 32'(Cnt_o_FND[20:14]), 32'(7'b0000110));

        // A long hold counts once.
        press("long_hold", 2'b01, 50, 10);

        // Simultaneous press: no change.
        press("both", 2'b00, 10, 10);

        // Random presses at varied spacing.
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0: p = 2'b01;
                1: p = 2'b10;
                2: p = 2'b00;
                default: p = 2'b11;
            endcase
            press("rand", p, int'($urandom_range(4, 12)), int'($urandom_range(4, 12)));
        end

        // Wrap in both directions.
        do_reset("wrap_rst");
        press("down_wrap", 2'b10, 10, 10);
        check("down_wrap_led", 32'(Cnt_o_LED), 32'h999);
        press("up_wrap", 2'b01, 10, 10);
        check("up_wrap_led", 32'(Cnt_o_LED), 32'h000);
        press("down_wrap2", 2'b10, 10, 10);
        for (int i = 0; i < 100; i++) press("down", 2'b10, 10, 10);
        check("down899_led", 32'(Cnt_o_LED), 32'h899);
        check("down899_ones_seg", 32'(Cnt_o_FND[6:0]), 32'(7'b1101111));

        // Alternating presses return to the start value.
        press("alt_up1", 2'b01, 10, 10);
        press("alt_dn1", 2'b10, 10, 10);
        press("alt_up2", 2'b01, 10, 10);
        press("alt_dn2", 2'b10, 10, 10);
        check("alt_led", 32'(Cnt_o_LED), 32'h899);

        // Reset mid-press, release while the button is still held.
        Push = 2'b01;
        repeat (2) @(posedge Clk);
        #1;
        do_reset("mid_rst");
        check_state("mid_rst_held");
        Push = 2'b11;
        repeat (10) @(posedge Clk);
        #1;
        check_state("mid_rst_release");
        press("mid_rst_repress", 2'b01, 10, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
